// File: rtl/prog_loader_if.sv
// Byte-stream, program-memory write and echo signals of the program loader.
// The loader is the slave: it consumes rx bytes and drives the write port and the echo.
interface prog_loader_if #(
    parameter int unsigned ROM_DEPTH = 16
);
    localparam int unsigned AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, wr_en, wr_addr, wr_data, tx_data, tx_valid
    );

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, wr_en, wr_addr, wr_data, tx_data, tx_valid
    );
endinterface

// File: rtl/prog_loader.sv
// Serial program writer: sync byte, ROM_DEPTH instruction bytes, mod-256 checksum.
// Define LOADER_ECHO_EN to echo every load/check byte back on the tx side.
module prog_loader #(
    parameter int unsigned ROM_DEPTH      = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    prog_loader_if.slave  bus,
    output logic          cpu_hold_o,
    output logic          load_ok_o,
    output logic          load_err_o
);
    localparam int unsigned AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] IdxLast  = AW'(ROM_DEPTH - 1);

`ifdef LOADER_ECHO_EN
    localparam bit EchoEn = 1'b1;
`else
    localparam bit EchoEn = 1'b0;
`endif

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          hold_q, hold_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          echo_pending;
    logic          rx_ready;
    logic          accept;

    assign echo_pending = EchoEn && tx_valid_q;
    assign rx_ready     = !echo_pending;
    assign accept       = bus.rx_valid && rx_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        tmo_d      = tmo_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        hold_d     = hold_q;
        ok_d       = ok_q;
        err_d      = err_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        if (echo_pending && bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept && bus.rx_data == SYNC_BYTE) begin
                    state_d = StLoad;
                    hold_d  = 1'b1;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                    tmo_d   = '0;
                end
            end
            StLoad: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = bus.rx_data;
                    sum_d     = sum_q + bus.rx_data;
                    tmo_d     = '0;
                    if (idx_q == IdxLast) begin
                        idx_d   = '0;
                        state_d = StCheck;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    tmo_d   = '0;
                    state_d = StIdle;
                    if (bus.rx_data == sum_q) begin
                        ok_d   = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Idle time inside a load; an outstanding echo is the loader's own stall, not idle.
        if ((state_q == StLoad || state_q == StCheck) && !accept && !echo_pending) begin
            if (tmo_q == TmoLast) begin
                state_d = StIdle;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (EchoEn && accept && state_q != StIdle) begin
            tx_valid_d = 1'b1;
            tx_data_d  = bus.rx_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            sum_q      <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hold_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign cpu_hold_o   = hold_q;
    assign load_ok_o    = ok_q;
    assign load_err_o   = err_q;
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program writer for the 16-entry x 8-bit instruction ROM that the CPU decode/ALU path executes.
- Consumes a byte stream from the UART receiver: sync byte, 16 instruction bytes, then checksum.
- Writes each byte into program memory and holds the CPU in reset while a load is in progress or after a failed load.
- Sits between the UART RX block and the program memory write port / CPU reset gate.

Parameters:
- ROM_DEPTH, 16, number of instruction bytes per image; address width is clog2(ROM_DEPTH).
- SYNC_BYTE, 8'hA5, byte that starts a load.
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside a load before abort.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data valid; a byte transfers when rx_valid && rx_ready
- rx_ready  output  1  loader can accept a byte
- wr_en  output  1  program memory write strobe
- wr_addr  output  clog2(ROM_DEPTH)  program memory write address
- wr_data  output  8  program memory write data
- cpu_hold  output  1  keeps the CPU in reset while high
- load_ok  output  1  last load passed checksum (level)
- load_err  output  1  last load failed: checksum mismatch or timeout (level)
- tx_data  output  8  echo byte (LOADER_ECHO_EN only)
- tx_valid  output  1  echo valid (LOADER_ECHO_EN only)
- tx_ready  input  1  UART TX accepts echo byte

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and sampled on the rising edge.
- Reset values:
  - state=IDLE; rx_ready=1.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cpu_hold=0, load_ok=0, load_err=0.
  - tx_valid=0, tx_data=0.
  - Byte index=0, running sum=0, timeout counter=0.
- rst mid-load: aborts immediately to the reset values. ROM bytes already written stay written.
- IDLE:
  - Accepted byte == SYNC_BYTE -> LOAD next cycle. Same edge: cpu_hold<=1, load_ok<=0, load_err<=0, index<=0, sum<=0, timeout<=0.
  - Any other byte is discarded with no output change.
- LOAD:
  - Each accepted byte is registered. Next cycle: wr_en=1 for exactly one cycle, wr_addr=index, wr_data=byte.
  - Same edge as acceptance: sum<=sum+byte (mod 256), index<=index+1.
  - After byte ROM_DEPTH-1 (index wraps to 0) -> CHECK.
  - A byte equal to SYNC_BYTE inside LOAD is treated as data, not as a restart.
- CHECK:
  - Next accepted byte compared against sum. Match -> load_ok<=1, cpu_hold<=0. Mismatch -> load_err<=1, cpu_hold stays 1.
  - Either way -> IDLE. No write in CHECK.
- Timeout:
  - In LOAD/CHECK, the counter increments every cycle without an accepted byte and clears on each accepted byte.
  - On reaching TIMEOUT_CYCLES-1: -> IDLE, load_err<=1, cpu_hold stays 1.
- Recovery: cpu_hold clears only on a later successful load or on rst.
- rx_ready:
  - 1 in every state unless an echo is pending.
  - A byte is accepted only when rx_valid && rx_ready. rx_valid while rx_ready=0 is not consumed; the upstream block holds it.
- Latency: accept edge -> wr_en high on the following cycle. Final checksum byte accept edge -> load_ok/load_err valid the next cycle.

Optional Feature:
- LOADER_ECHO_EN defined:
  - Every accepted byte in LOAD and CHECK (not IDLE bytes, not the sync byte) is loaded into tx_data with tx_valid=1 on the next cycle.
  - tx_valid holds until tx_valid && tx_ready; then it drops.
  - rx_ready=0 from acceptance until the echo handshake completes.
  - Timeout counting pauses while an echo is pending.
- LOADER_ECHO_EN undefined:
  - tx_valid=0 and tx_data=0 constantly; tx_ready is ignored.
  - rx_ready is governed only by the rest of Behaviour.

Test Plan:
- Normal load: send A5, bytes 00..0F, checksum 78 -> 16 wr_en pulses at addr 0..15 with data 00..0F; load_ok=1, load_err=0, cpu_hold=0.
- Bad checksum: send A5, 16 x 11, then 00 (expected 10) -> 16 writes of 11; load_err=1, load_ok=0, cpu_hold=1. A following good load of A5, 16 x 01, 10 -> load_ok=1, cpu_hold=0.
- Noise in IDLE, then a sync byte inside data: send 3C, FF, then A5 -> nothing happens before A5. Then send A5 as data byte 0 -> written to addr 0; no restart.
- Timeout: with TIMEOUT_CYCLES=32, send A5 and 3 bytes, then go idle -> IDLE after 32 idle cycles; load_err=1, cpu_hold=1, exactly 3 writes.
- Reset mid-load: assert rst after byte 7 -> next cycle cpu_hold=0, state IDLE, no further writes. Next byte 00 is ignored.
- Echo (LOADER_ECHO_EN, tx_ready held 0 for 5 cycles): send A5, 42 -> tx_valid=1 with tx_data=42; rx_ready=0 until tx_ready rises, then 1.
